// File: rtl/fake_slave_pkg.sv
// Shared types and bus-width defaults for the fake WISHBONE slave.
// Bus widths and MAX_BURST_LENGHT come from the NIC defines when already present.
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 8
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 8
`endif
`ifndef MAX_BURST_LENGHT
`define MAX_BURST_LENGHT 8
`endif

package fake_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  localparam int unsigned MAX_BURST = `MAX_BURST_LENGHT;

  function automatic logic [`BUS_DATA_WIDTH-1:0] byte_merge(
    input logic [`BUS_DATA_WIDTH-1:0] old_w,
    input logic [`BUS_DATA_WIDTH-1:0] new_w,
    input logic [`BUS_SEL_WIDTH-1:0]  sel
  );
    logic [`BUS_DATA_WIDTH-1:0] r;
    r = old_w;
    for (int unsigned b = 0; b < `BUS_SEL_WIDTH; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fake_slave_lfsr.sv
// 8-bit maximal Fibonacci LFSR (x^8+x^6+x^5+x^4+1) driving random slave stalls.
// Present only when FAKE_SLAVE_STALL_EN is defined.
`ifdef FAKE_SLAVE_STALL_EN
module fake_slave_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] lfsr_o
);
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;
endmodule
`endif

// File: rtl/fake_slave.sv
// Memory-backed WISHBONE burst slave with error on over-long bursts and cycle counters.
// Define FAKE_SLAVE_STALL_EN to enable pseudo-random STALL_O from fake_slave_lfsr.
module fake_slave
  import fake_slave_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          CYC_I,
  input  logic                          STB_I,
  input  logic                          WE_I,
  input  logic [`BUS_ADDRESS_WIDTH-1:0] ADR_I,
  input  logic [`BUS_DATA_WIDTH-1:0]    DAT_I,
  input  logic [`BUS_SEL_WIDTH-1:0]     SEL_I,
  input  logic [`BUS_TGA_WIDTH-1:0]     TGA_I,
  input  logic [`BUS_TGC_WIDTH-1:0]     TGC_I,
  input  logic [2:0]                    CTI_I,
  output logic [`BUS_DATA_WIDTH-1:0]    DAT_O,
  output logic                          ACK_O,
  output logic                          ERR_O,
  output logic                          RTY_O,
  output logic                          STALL_O,
  output logic [15:0]                   n_writes_o,
  output logic [15:0]                   n_reads_o
);
  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_e                       state_q;
  logic [7:0]                   beat_cnt_q;
  logic                         ack_q, err_q, acked_q, first_we_q;
  logic [`BUS_DATA_WIDTH-1:0]   dat_q;
  logic [`BUS_DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic [15:0]                  n_wr_q, n_rd_q;
  logic                         stall, accept, err_beat;
  logic [AW-1:0]                idx;

`ifdef FAKE_SLAVE_STALL_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;

  fake_slave_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i  (clk),
    .rst_i  (rst),
    .lfsr_o (lfsr)
  );
  assign stall       = (state_q != ST_IDLE) & lfsr[0];
  assign unused_lfsr = ^lfsr[7:1];
`else
  assign stall = 1'b0;
`endif

  logic unused_in;
  assign unused_in = ^{TGA_I, TGC_I, CTI_I, ADR_I};

  assign accept   = CYC_I & STB_I & ~stall;
  assign err_beat = (state_q == ST_ERROR) || (beat_cnt_q == 8'(MAX_BURST));
  assign idx      = ADR_I[AW-1:0] + beat_cnt_q[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      acked_q    <= 1'b0;
      first_we_q <= 1'b0;
      dat_q      <= '0;
      n_wr_q     <= '0;
      n_rd_q     <= '0;
      mem_q      <= '{default: '0};
    end else begin
      ack_q <= accept & ~err_beat;
      err_q <= accept & err_beat;
      if (accept && !err_beat) begin
        if (WE_I) mem_q[idx] <= byte_merge(mem_q[idx], DAT_I, SEL_I);
        else      dat_q      <= mem_q[idx];
      end
      if (!CYC_I) begin
        state_q    <= ST_IDLE;
        beat_cnt_q <= '0;
        acked_q    <= 1'b0;
        // A cycle is counted as it ends, and only if the master saw an ACK.
        if (state_q != ST_IDLE && acked_q) begin
          if (first_we_q) n_wr_q <= n_wr_q + 16'd1;
          else            n_rd_q <= n_rd_q + 16'd1;
        end
      end else begin
        if (accept && beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 8'd1;
        if (accept && beat_cnt_q == '0) first_we_q <= WE_I;
        if (ACK_O) acked_q <= 1'b1;
        case (state_q)
          ST_IDLE:   state_q <= ST_ACTIVE;
          ST_ACTIVE: if (accept && err_beat) state_q <= ST_ERROR;
          default:   ;
        endcase
      end
    end
  end

  // Responses are suppressed combinationally so an aborted cycle sees none.
  assign ACK_O      = ack_q & CYC_I;
  assign ERR_O      = err_q & CYC_I;
  assign RTY_O      = 1'b0;
  assign STALL_O    = stall;
  assign DAT_O      = dat_q;
  assign n_writes_o = n_wr_q;
  assign n_reads_o  = n_rd_q;
endmodule

// File: tb/tb_fake_slave.sv
// Directed self-checking bench for fake_slave (MEM_DEPTH=16).
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif
`ifndef BUS_TGA_WIDTH
`define BUS_TGA_WIDTH 8
`endif
`ifndef BUS_TGC_WIDTH
`define BUS_TGC_WIDTH 8
`endif
`ifndef MAX_BURST_LENGHT
`define MAX_BURST_LENGHT 8
`endif

module tb_fake_slave;
  localparam int unsigned MAXB = `MAX_BURST_LENGHT;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic [`BUS_ADDRESS_WIDTH-1:0] ADR_I = '0;
  logic [`BUS_DATA_WIDTH-1:0]    DAT_I = '0;
  logic [`BUS_SEL_WIDTH-1:0]     SEL_I = '0;
  logic [`BUS_TGA_WIDTH-1:0]     TGA_I = '1;
  logic [`BUS_TGC_WIDTH-1:0]     TGC_I = '1;
  logic [2:0]                    CTI_I = 3'b111;
  logic [`BUS_DATA_WIDTH-1:0]    DAT_O;
  logic                          ACK_O, ERR_O, RTY_O, STALL_O;
  logic [15:0]                   n_writes_o, n_reads_o;

  int unsigned errors = 0, checks = 0;
  logic [31:0] mdl [16];
  logic [15:0] exp_nw = '0, exp_nr = '0;

  always #5 clk = ~clk;

  fake_slave #(.MEM_DEPTH(16), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I), .TGA_I(TGA_I), .TGC_I(TGC_I),
    .CTI_I(CTI_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .ERR_O(ERR_O), .RTY_O(RTY_O),
    .STALL_O(STALL_O), .n_writes_o(n_writes_o), .n_reads_o(n_reads_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  // Hold STB_I until the DUT accepts (bounded), leaving the response visible.
  task automatic do_beat(input string tag);
    int unsigned n;
    logic acc;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      acc = !STALL_O;
      tick();
      n++;
    end
    if (!acc) chk({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic burst(input logic we, input logic [3:0] base, input int unsigned n,
                       input logic [31:0] seed, input logic [3:0] sel);
    int unsigned issued, cycles, acks;
    logic acc, is_err;
    logic [3:0] idx;
    issued = 0; cycles = 0; acks = 0;
    CYC_I = 1'b1; WE_I = we; SEL_I = sel;
    ADR_I = {{(`BUS_ADDRESS_WIDTH-4){1'b0}}, base};
    while (issued < n && cycles < 400) begin
      STB_I  = 1'b1;
      DAT_I  = seed + issued;
      acc    = !STALL_O;
      is_err = (issued >= MAXB);
      idx    = base + issued[3:0];
      if (acc && we && !is_err) mdl[idx] = merge(mdl[idx], DAT_I, sel);
      tick();
      cycles++;
      chk("ack", {31'b0, ACK_O}, {31'b0, acc & ~is_err});
      chk("err", {31'b0, ERR_O}, {31'b0, acc & is_err});
`ifndef FAKE_SLAVE_STALL_EN
      chk("stall_off", {31'b0, STALL_O}, 32'd0);
`endif
      if (acc && !we && !is_err) chk("rdata", DAT_O, mdl[idx]);
      if (acc) begin
        issued++;
        if (!is_err) acks++;
      end
    end
    if (issued < n) chk("burst_timeout", issued, n);
    STB_I = 1'b0;
    tick();
    chk("no_extra_ack", {30'b0, ACK_O, ERR_O}, 32'd0);
    CYC_I = 1'b0;
    tick();
    if (acks > 0) begin
      if (we) exp_nw++;
      else    exp_nr++;
    end
    chk("n_writes", {16'b0, n_writes_o}, {16'b0, exp_nw});
    chk("n_reads",  {16'b0, n_reads_o},  {16'b0, exp_nr});
    chk("idle_stall", {31'b0, STALL_O}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    tick(); tick();
    chk("rst_ack",   {31'b0, ACK_O},   32'd0);
    chk("rst_err",   {31'b0, ERR_O},   32'd0);
    chk("rst_rty",   {31'b0, RTY_O},   32'd0);
    chk("rst_stall", {31'b0, STALL_O}, 32'd0);
    chk("rst_dat",   DAT_O, 32'd0);
    chk("rst_nw",    {16'b0, n_writes_o}, 32'd0);
    chk("rst_nr",    {16'b0, n_reads_o},  32'd0);
    rst = 1'b0;
    tick();

    // Single write then read at 0x3
    burst(1'b1, 4'h3, 1, 32'hDEADBEEF, 4'hF);
    burst(1'b0, 4'h3, 1, 32'h0, 4'hF);
    chk("single_rd", DAT_O, 32'hDEADBEEF);
    chk("single_nw", {16'b0, n_writes_o}, 32'd1);
    chk("single_nr", {16'b0, n_reads_o},  32'd1);
    chk("rty_low",   {31'b0, RTY_O},      32'd0);

    // Full-length wrapping burst from 0xE, read back
    burst(1'b1, 4'hE, MAXB, 32'h1000_0000, 4'hF);
    burst(1'b0, 4'hE, MAXB, 32'h0, 4'hF);
    burst(1'b0, 4'h0, 1, 32'h0, 4'hF);
    chk("wrap_idx0", DAT_O, 32'h1000_0002);

    // Over-long burst: last beat errors and leaves its word untouched
    burst(1'b1, 4'h8, 1, 32'hCAFE_F00D, 4'hF);
    burst(1'b1, 4'h0, MAXB + 1, 32'h2000_0000, 4'hF);
    burst(1'b0, 4'h8, 1, 32'h0, 4'hF);
    chk("err_nowrite", DAT_O, 32'hCAFE_F00D);
    burst(1'b0, 4'h7, 1, 32'h0, 4'hF);
    chk("err_prev_beat", DAT_O, 32'h2000_0007);

    // Byte-lane write
    burst(1'b1, 4'h9, 1, 32'hAAAA_AAAA, 4'hF);
    burst(1'b1, 4'h9, 1, 32'h1122_3344, 4'b0010);
    burst(1'b0, 4'h9, 1, 32'h0, 4'hF);
    chk("sel_merge", DAT_O, 32'hAAAA_33AA);

    // Abort after the 2nd of 4 beats
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; SEL_I = 4'hF;
    ADR_I = {{(`BUS_ADDRESS_WIDTH-4){1'b0}}, 4'h5};
    DAT_I = 32'h5555_5555;
    do_beat("abort_b0");
    chk("abort_ack0", {31'b0, ACK_O}, 32'd1);
    DAT_I = 32'h6666_6666;
    do_beat("abort_b1");
    chk("abort_ack1", {31'b0, ACK_O}, 32'd1);
    CYC_I = 1'b0; STB_I = 1'b0;
    #1;
    chk("abort_gated", {30'b0, ACK_O, ERR_O}, 32'd0);
    tick();
    exp_nw++;
    mdl[5] = 32'h5555_5555;
    mdl[6] = 32'h6666_6666;
    chk("abort_nw", {16'b0, n_writes_o}, {16'b0, exp_nw});
    burst(1'b0, 4'h5, 1, 32'h0, 4'hF);
    chk("abort_restart", DAT_O, 32'h5555_5555);

`ifdef FAKE_SLAVE_STALL_EN
    burst(1'b0, 4'hE, 4, 32'h0, 4'hF);
`endif

    // Reset during an accepted beat suppresses the ACK and clears state
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; SEL_I = 4'hF;
    ADR_I = {{(`BUS_ADDRESS_WIDTH-4){1'b0}}, 4'h3};
    DAT_I = 32'h1234_5678;
    rst = 1'b1;
    tick();
    chk("rst_mid_ack", {31'b0, ACK_O}, 32'd0);
    rst = 1'b0; CYC_I = 1'b0; STB_I = 1'b0;
    tick();
    chk("rst_mid_nw", {16'b0, n_writes_o}, 32'd0);
    chk("rst_mid_dat", DAT_O, 32'd0);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    exp_nw = '0;
    exp_nr = '0;
    burst(1'b0, 4'h3, 1, 32'h0, 4'hF);
    chk("rst_mem_clr", DAT_O, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fake_slave.md
FAKE_SLAVE -- requirements
Module: fake_slave

Interface
REQ-001 Parameter MEM_DEPTH, default 16, SHALL set the internal word count; it SHALL be a power of two, 2..256.
REQ-002 Parameter LFSR_SEED, default 8'hA5, SHALL set the stall LFSR reset value; it SHALL be non-zero.
REQ-003 clk  input  1  SHALL be the only clock; the block SHALL sample on the rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 CYC_I  input  1  SHALL carry the WISHBONE cycle qualifier.
REQ-006 STB_I  input  1  SHALL carry the beat strobe.
REQ-007 WE_I  input  1  SHALL mark a write (1) or a read (0).
REQ-008 ADR_I  input  `BUS_ADDRESS_WIDTH  SHALL carry the burst base address, constant for the whole cycle.
REQ-009 DAT_I  input  `BUS_DATA_WIDTH  SHALL carry write data.
REQ-010 SEL_I  input  `BUS_SEL_WIDTH  SHALL carry per-byte write enables.
REQ-011 TGA_I  input  `BUS_TGA_WIDTH, TGC_I  input  `BUS_TGC_WIDTH, CTI_I  input  3  SHALL be accepted and ignored.
REQ-012 DAT_O  output  `BUS_DATA_WIDTH  SHALL carry read data, valid with ACK_O.
REQ-013 ACK_O, ERR_O, RTY_O, STALL_O  output  1 each  SHALL carry the slave handshake.
REQ-014 n_writes_o, n_reads_o  output  16 each  SHALL count completed write and read cycles.

Function
REQ-015 A beat SHALL be accepted when CYC_I && STB_I && !STALL_O; STB_I without CYC_I SHALL be ignored.
REQ-016 beat_cnt SHALL count accepted beats in the current cycle; it SHALL clear when CYC_I is low.
REQ-017 Word index SHALL be (ADR_I[log2(MEM_DEPTH)-1:0] + beat_cnt) mod MEM_DEPTH, wrapping silently.
REQ-018 An accepted write SHALL update only the bytes of mem[index] whose SEL_I bits are set, at the acceptance edge.
REQ-019 An accepted read SHALL register mem[index] onto DAT_O one cycle after acceptance.
REQ-020 ACK_O SHALL assert exactly one cycle after each accepted beat, one pulse per beat; back-to-back beats SHALL give back-to-back ACKs.
REQ-021 The FSM SHALL have states IDLE, ACTIVE and ERROR; IDLE->ACTIVE on CYC_I; ACTIVE->ERROR on accepting a beat with beat_cnt == `MAX_BURST_LENGHT; ACTIVE/ERROR->IDLE when CYC_I is low.
REQ-022 In ERROR, and for the beat that causes the ACTIVE->ERROR transition, each accepted beat SHALL return ERR_O instead of ACK_O one cycle later, with no memory write.
REQ-023 ACK_O and ERR_O SHALL be gated low in any cycle where CYC_I is low, so a cycle aborted mid-burst receives no further responses.
REQ-024 RTY_O SHALL be held at 0.
REQ-025 On CYC_I falling with at least one ACK issued, the block SHALL increment n_writes_o if the first beat had WE_I=1, otherwise n_reads_o, wrapping at 16'hFFFF.
REQ-026 A read accepted in the same cycle as a write to the same index SHALL return the pre-write value.

Reset
REQ-027 While rst is high: state=IDLE, beat_cnt=0, ACK_O=ERR_O=RTY_O=STALL_O=0, DAT_O=0, counters=0, every mem word=0, LFSR=LFSR_SEED.
REQ-028 rst asserted mid-burst SHALL abort the cycle without issuing the pending ACK.

Configuration
REQ-029 With FAKE_SLAVE_STALL_EN defined: an 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle, and STALL_O SHALL equal lfsr[0] while in ACTIVE or ERROR, and 0 in IDLE.
REQ-030 Without FAKE_SLAVE_STALL_EN: STALL_O SHALL be constantly 0, and no LFSR logic SHALL be synthesized.

Structure
REQ-031 FSM state encodings and any new bus widths SHALL live in the shared NIC-defines.v; existing `BUS_* and `MAX_BURST_LENGHT defines SHALL be reused.
REQ-032 The LFSR SHALL be a sub-module fake_slave_lfsr, instantiated only under FAKE_SLAVE_STALL_EN.

Verification
REQ-033 Single write, ADR_I=0x3, DAT_I=0xDEADBEEF, SEL_I all-ones -> ACK_O one cycle later; a later read at 0x3 returns 0xDEADBEEF; n_writes_o=1, n_reads_o=1.
REQ-034 Write burst of `MAX_BURST_LENGHT beats from base 0xE (MEM_DEPTH=16) -> indices wrap 14,15,0,1...; one ACK per beat; readback matches.
REQ-035 Burst of `MAX_BURST_LENGHT+1 beats -> the last beat gets ERR_O, with no memory change; state returns to IDLE after CYC_I drops.
REQ-036 CYC_I dropped in the cycle after the 2nd of 4 beats -> no ACK in that cycle; the counter increments once; the next cycle starts at beat_cnt=0.
REQ-037 SEL_I=4'b0010 write of 0x11223344 over 0xAAAAAAAA -> reads 0xAAAA33AA.
REQ-038 With FAKE_SLAVE_STALL_EN, a 4-beat read under random STALL_O -> exactly 4 ACKs, data in order, and no beat accepted while STALL_O=1.
